// File: rtl/register_file_wb_pkg.sv
// ---------------------------------------------------------------------------
// JZJCoreFTypes
// Shared types for the integer register file and its write-back path.
//   XLEN               : datapath width (32)
//   RegisterIndex_t    : 5-bit architectural register index (x0..x31)
//   RegFileWritePort_t : {data, address, writeEnable} bundle for one write
//   ZERO_REGISTER      : index of the hard-wired zero register x0
// ---------------------------------------------------------------------------
package JZJCoreFTypes;

  localparam int XLEN = 32;

  typedef logic [4:0] RegisterIndex_t;

  localparam RegisterIndex_t ZERO_REGISTER = 5'd0;

  typedef struct packed {
    logic [XLEN-1:0] data;
    RegisterIndex_t  address;
    logic            writeEnable;
  } RegFileWritePort_t;

endpackage

// File: rtl/register_file_wb_read_port.sv
// ---------------------------------------------------------------------------
// register_file_read_port
// One combinational read port of the register file.  It resolves x0, a read
// of the register that has an uncommitted write in staging, and a plain array
// read.
// Build option: REG_FILE_BYPASS_EN
//   defined   : the staged data is forwarded, hazard_o is always 0
//   undefined : the stale array word is returned and hazard_o asserts
// Ports:
//   address_i         read index
//   array_word_i      array contents at address_i
//   pending_valid_i   staging register holds an uncommitted write
//   pending_address_i staging destination index
//   pending_data_i    staging write data
//   data_o            read data
//   hazard_o          read depends on an uncommitted write (no-bypass build)
// ---------------------------------------------------------------------------
module register_file_read_port
  import JZJCoreFTypes::*;
(
  input  logic [4:0]  address_i,
  input  logic [31:0] array_word_i,
  input  logic        pending_valid_i,
  input  logic [4:0]  pending_address_i,
  input  logic [31:0] pending_data_i,
  output logic [31:0] data_o,
  output logic        hazard_o
);

  logic pending_hit;

  assign pending_hit = pending_valid_i && (address_i == pending_address_i);

`ifndef REG_FILE_BYPASS_EN
  // Staged data is never forwarded in this build.
  logic unused_pending_data;
  assign unused_pending_data = ^pending_data_i;
`endif

  always_comb begin
    data_o   = array_word_i;
    hazard_o = 1'b0;
    if (address_i == ZERO_REGISTER) begin
      data_o = '0;
    end else if (pending_hit) begin
`ifdef REG_FILE_BYPASS_EN
      data_o = pending_data_i;
`else
      // Array still holds the old value; the consumer must stall a cycle.
      hazard_o = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/register_file_wb.sv
// ---------------------------------------------------------------------------
// register_file_wb
// Integer register file x0..x31 with a one-entry write-back staging register.
// A write is captured into staging on one edge and committed to the array on
// the following edge; two read ports resolve x0, staged data and array data.
// Build option: REG_FILE_BYPASS_EN (forward staged data instead of flagging a
// hazard, see register_file_read_port).
// Ports:
//   clock, reset          core clock, asynchronous active-high reset
//   rd, rdAddress         write-back data and destination index
//   rdWriteEnable         capture rd/rdAddress on this edge
//   rs1Address/rs2Address read indices
//   rs1/rs2               read data (combinational)
//   rs1Hazard/rs2Hazard   read targets an uncommitted write
//   pendingValid          staging register holds an uncommitted write
// ---------------------------------------------------------------------------
module register_file_wb
  import JZJCoreFTypes::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rd,
  input  logic [4:0]  rdAddress,
  input  logic        rdWriteEnable,
  input  logic [4:0]  rs1Address,
  input  logic [4:0]  rs2Address,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic        rs1Hazard,
  output logic        rs2Hazard,
  output logic        pendingValid
);

  RegFileWritePort_t write_port;
  // Staging entry; its writeEnable field doubles as pendingValid.
  RegFileWritePort_t pending_q;
  RegFileWritePort_t pending_d;

  logic [31:0] regs_q     [1:31];
  logic [31:0] read_words [0:31];

  assign write_port = '{data: rd, address: rdAddress, writeEnable: rdWriteEnable};

  // Capture replaces the staged entry (the old one commits on the same edge);
  // otherwise the entry is retired. Writes to x0 are dropped here.
  always_comb begin
    pending_d             = pending_q;
    pending_d.writeEnable = 1'b0;
    if (write_port.writeEnable && (write_port.address != ZERO_REGISTER)) begin
      pending_d = write_port;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // x0 has no storage; its read word is a constant zero.
  assign read_words[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_regs
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        regs_q[gi] <= '0;
      end else if (pending_q.writeEnable && (pending_q.address == 5'(gi))) begin
        regs_q[gi] <= pending_q.data;
      end
    end
    assign read_words[gi] = regs_q[gi];
  end

  register_file_read_port u_rs1_port (
    .address_i        (rs1Address),
    .array_word_i     (read_words[rs1Address]),
    .pending_valid_i  (pending_q.writeEnable),
    .pending_address_i(pending_q.address),
    .pending_data_i   (pending_q.data),
    .data_o           (rs1),
    .hazard_o         (rs1Hazard)
  );

  register_file_read_port u_rs2_port (
    .address_i        (rs2Address),
    .array_word_i     (read_words[rs2Address]),
    .pending_valid_i  (pending_q.writeEnable),
    .pending_address_i(pending_q.address),
    .pending_data_i   (pending_q.data),
    .data_o           (rs2),
    .hazard_o         (rs2Hazard)
  );

  assign pendingValid = pending_q.writeEnable;

endmodule

// File: tb/tb_register_file_wb.sv
// ---------------------------------------------------------------------------
// tb_register_file_wb
// Directed and random stimulus for register_file_wb, checked against an
// architectural model: committed register values plus a list of writes that
// have been accepted but not yet reached the array.
// ---------------------------------------------------------------------------
module tb_register_file_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rd;
  logic [4:0]  rdAddress;
  logic        rdWriteEnable;
  logic [4:0]  rs1Address;
  logic [4:0]  rs2Address;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        rs1Hazard;
  logic        rs2Hazard;
  logic        pendingValid;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] committed [32];
  wr_t         in_flight [$];

  register_file_wb dut (
    .clock        (clock),
    .reset        (reset),
    .rd           (rd),
    .rdAddress    (rdAddress),
    .rdWriteEnable(rdWriteEnable),
    .rs1Address   (rs1Address),
    .rs2Address   (rs2Address),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1Hazard    (rs1Hazard),
    .rs2Hazard    (rs2Hazard),
    .pendingValid (pendingValid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) committed[i] = '0;
    in_flight.delete();
  endtask

  // Architectural expectation for a read: x0 is zero; a register with an
  // outstanding write shows the new value only with forwarding enabled.
  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic hz);
    d  = committed[a];
    hz = 1'b0;
    if (a == 5'd0) begin
      d = '0;
    end else begin
      foreach (in_flight[i]) begin
        if (in_flight[i].addr == a) begin
          if (BYPASS) d = in_flight[i].data;
          else hz = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string where);
    logic [31:0] d;
    logic        hz;
    model_read(rs1Address, d, hz);
    chk({where, ".rs1"}, rs1, d);
    chk({where, ".rs1Hazard"}, 32'(rs1Hazard), 32'(hz));
    model_read(rs2Address, d, hz);
    chk({where, ".rs2"}, rs2, d);
    chk({where, ".rs2Hazard"}, 32'(rs2Hazard), 32'(hz));
    chk({where, ".pendingValid"}, 32'(pendingValid), 32'(in_flight.size() != 0));
  endtask

  // Model of one rising edge: everything outstanding lands in the array,
  // then an accepted write (non-x0) becomes outstanding.
  task automatic model_edge(input logic we, input logic [4:0] a, input logic [31:0] d);
    while (in_flight.size() != 0) begin
      wr_t w;
      w = in_flight.pop_front();
      committed[w.addr] = w.data;
    end
    if (we && a != 5'd0) in_flight.push_back('{addr: a, data: d});
  endtask

  // Called at posedge+1: drive, check at the falling edge, take the edge.
  task automatic cycle(input string tag, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    rdWriteEnable = we;
    rdAddress     = a;
    rd            = d;
    rs1Address    = r1;
    rs2Address    = r2;
    #4;
    check_all(tag);
    $display("txn %-10s we=%0b rdAddr=%0d rd=%h rs1Addr=%0d rs1=%h hz1=%0b rs2Addr=%0d rs2=%h hz2=%0b pv=%0b",
             tag, we, a, d, r1, rs1, rs1Hazard, r2, rs2, rs2Hazard, pendingValid);
    @(posedge clock);
    model_edge(we, a, d);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    rd            = '0;
    rdAddress     = '0;
    rdWriteEnable = 1'b0;
    rs1Address    = 5'd5;
    rs2Address    = 5'd31;
    model_clear();
    #2;
    chk("reset.rs1", rs1, 32'h0);
    chk("reset.rs2", rs2, 32'h0);
    chk("reset.pendingValid", 32'(pendingValid), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Write to x0 is discarded.
    cycle("x0wr", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    cycle("x0chk", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("x0.pendingValid", 32'(pendingValid), 32'h0);
    chk("x0.rs1", rs1, 32'h0);

    // Pending read of x7.
    cycle("x7wr", 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd0);
    chk("x7.pend.rs1", rs1, BYPASS ? 32'h1234_5678 : 32'h0);
    chk("x7.pend.hz", 32'(rs1Hazard), BYPASS ? 32'h0 : 32'h1);
    cycle("x7pend", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    chk("x7.commit.rs1", rs1, 32'h1234_5678);
    chk("x7.commit.hz", 32'(rs1Hazard), 32'h0);
    cycle("x7done", 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);

    // Back-to-back writes to the same register.
    cycle("x3a", 1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
    cycle("x3b", 1'b1, 5'd3, 32'h2, 5'd3, 5'd3);
    chk("x3.pendingValid", 32'(pendingValid), 32'h1);
    cycle("x3pend", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    cycle("x3done", 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    chk("x3.final", rs1, 32'h2);

    // Back-to-back writes to different registers.
    cycle("x1wr", 1'b1, 5'd1, 32'hA, 5'd1, 5'd2);
    cycle("x2wr", 1'b1, 5'd2, 32'hB, 5'd1, 5'd2);
    cycle("x12pend", 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    cycle("x12done", 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    chk("x12.rs1", rs1, 32'hA);
    chk("x12.rs2", rs2, 32'hB);
    chk("x12.pendingValid", 32'(pendingValid), 32'h0);

    // Both ports reading a pending x9.
    cycle("x9wr", 1'b1, 5'd9, 32'h9999_0001, 5'd0, 5'd0);
    cycle("x9dual", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);

    // Random traffic biased toward a few registers to provoke hits.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      cycle("rand", 1'($urandom_range(0, 2) != 0), wa, $urandom(),
            5'($urandom_range(0, 5)), 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-cycle while x6 is pending and x5 committed.
    cycle("x5wr", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
    cycle("x6wr", 1'b1, 5'd6, 32'h0000_0066, 5'd5, 5'd6);
    rdWriteEnable = 1'b0;
    rs1Address    = 5'd5;
    rs2Address    = 5'd6;
    #1;
    chk("prerst.rs1", rs1, 32'hDEAD_BEEF);
    chk("prerst.pendingValid", 32'(pendingValid), 32'h1);
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst.rs1", rs1, 32'h0);
    chk("rst.pendingValid", 32'(pendingValid), 32'h0);
    chk("rst.rs2Hazard", 32'(rs2Hazard), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle("postrst", 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    cycle("postrst2", 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_wb.md
# register_file_wb

Integer register file (x0–x31) with a one-entry write-back staging register. It sits downstream of the rd source chooser: it accepts the selected rd value and destination address, stages the write for one cycle, then commits it to the register array. It drives the rs1/rs2 operands to the ALU, branch ALU and memory address path.

## Interface
Parameters:
- none; width fixed at 32 bits, 32 registers.

Ports:
- clock  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- rd  input  32  write-back data from rd source chooser
- rdAddress  input  5  destination register index
- rdWriteEnable  input  1  capture rd/rdAddress this edge
- rs1Address  input  5  read port 1 index
- rs2Address  input  5  read port 2 index
- rs1  output  32  read port 1 data (combinational)
- rs2  output  32  read port 2 data (combinational)
- rs1Hazard  output  1  rs1 reads a register with an uncommitted write
- rs2Hazard  output  1  rs2 reads a register with an uncommitted write
- pendingValid  output  1  staging register holds an uncommitted write

## Operation
- State:
  - array x1–x31, 32 bits each; x0 has no storage.
  - Staging register: pendingValid, pendingAddress[4:0], pendingData[31:0].
- Capture: on a rising edge with rdWriteEnable=1 and rdAddress≠0, load the staging register with rd/rdAddress and set pendingValid=1.
  - rdWriteEnable=1 with rdAddress=0 is discarded; the staging register is not loaded.
- Commit: on any rising edge with pendingValid=1, write pendingData to array[pendingAddress].
  - If no new capture occurs on the same edge, pendingValid clears.
  - Commit and capture on the same edge both occur: the old entry goes to the array, the new entry goes to staging, and pendingValid stays 1.
  - Back-to-back writes to the same address: the older value commits first, and the newer value overwrites it one cycle later. The final array value is the newer one.
- Read priority, per port:
  1. Address 0 → 32'h00000000, hazard 0.
  2. pendingValid and address==pendingAddress → behaviour set by configuration (see below).
  3. Otherwise → array contents, hazard 0.
- Reset (asynchronous): array cleared to 0, pendingValid=0, pendingAddress=0, pendingData=0.
  - All outputs therefore read 0 during and after reset.
  - A write captured before reset asserts is lost.

## Timing
- Write captured at edge N; committed to the array at edge N+1.
- Without bypass, a read returns the new value from the cycle after edge N+1 onward.
- With bypass, a read returns the new value immediately after edge N.
- Read ports have zero latency: combinational from address, array and staging state.
- rs1Hazard and rs2Hazard are combinational. They are valid in the same cycle as the address.
- Reset deassertion is synchronised externally; the block needs no recovery cycles.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - Rule 2 forwards pendingData to the read port.
  - rs1Hazard and rs2Hazard are tied to 0.
- REG_FILE_BYPASS_EN undefined:
  - Rule 2 returns the stale array value.
  - The matching hazard output asserts. Control logic must stall one cycle.
- pendingValid behaves identically in both builds.

## Structure
- JZJCoreFTypes package gains:
  - RegisterIndex_t, a 5-bit typedef.
  - RegFileWritePort_t, a struct of {data, address, writeEnable}.
  - The constant ZERO_REGISTER = 5'd0.
- Sub-module register_file_read_port holds the priority/bypass/hazard logic.
  - It is instantiated twice, once for rs1 and once for rs2.
  - It takes the array word, staging state and port address.
- Array and staging register live in the top module.

## Test plan
- Reset: assert reset mid-run after writing x5=32'hDEADBEEF → rs1Address=5 reads 0 and pendingValid=0, asynchronously before the next edge.
- x0 write: rdWriteEnable=1, rdAddress=0, rd=32'hFFFFFFFF → pendingValid stays 0 and rs1Address=0 reads 0.
- Pending read, x7=32'h12345678 captured at edge N, rs1Address=7 in cycle N:
  - with REG_FILE_BYPASS_EN: rs1=32'h12345678 and rs1Hazard=0;
  - without it: rs1=old value 0 and rs1Hazard=1;
  - both builds: 32'h12345678 and hazard 0 after edge N+1.
- Back-to-back same address: x3=32'h1 at edge N, x3=32'h2 at edge N+1 → pendingValid stays 1 through N+1, and the array holds x3=2 after edge N+2.
- Back-to-back different addresses: x1=32'hA then x2=32'hB on consecutive edges → both committed, rs1=A and rs2=B two edges after the last capture, pendingValid=0.
- Dual-port same address: rs1Address=rs2Address=9 with x9 pending → both ports return identical data and identical hazard values.
